// File: rtl/memory_arbiter_pkg.sv
// memory_bus_pkg: state encoding, port indices and default widths for the memory arbiter
package memory_bus_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;
  localparam int unsigned PORT_CORE = 0;
  localparam int unsigned PORT_DMA = 1;
  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_TIMEOUT = 255;
  function automatic logic [1:0] port_onehot(input logic id);
    return id == 1'(PORT_DMA) ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: requester-side and memory-side signals of the shared memory arbiter
interface memory_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = memory_bus_pkg::DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = memory_bus_pkg::DEF_DATA_WIDTH
);
  logic [1:0] req;
  logic [1:0] we;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic [DATA_WIDTH/8-1:0] wstrb0;
  logic [DATA_WIDTH/8-1:0] wstrb1;
  logic [1:0] ack;
  logic err;
  logic [DATA_WIDTH-1:0] rdata;
  logic mem_valid;
  logic mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_wstrb;
  logic mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic grant_id;
  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, wstrb0, wstrb1, mem_ready, mem_rdata,
    output ack, err, rdata, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, grant_id
  );
  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, wstrb0, wstrb1, mem_ready, mem_rdata,
    input  ack, err, rdata, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, grant_id
  );
endinterface

// File: rtl/memory_arbiter_rr.sv
// rr_arbiter_2: two-way grant, round-robin or core-first on ties; pointer moves only on a taken grant
module rr_arbiter_2
  import memory_bus_pkg::*;
#(
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] eligible_i,
  input  logic       take_i,
  output logic       grant_o,
  output logic       any_o
);
  logic ptr_q, ptr_d;
  assign any_o = |eligible_i;
  always_comb begin
    grant_o = eligible_i == 2'b10 ? 1'b1 :
              eligible_i == 2'b01 ? 1'b0 :
              FIXED_PRIORITY != 0 ? 1'(PORT_CORE) : ptr_q;
    ptr_d = take_i && any_o ? ~grant_o : ptr_q;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) ptr_q <= 1'(PORT_CORE);
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory between core (port 0) and DMA (port 1), one access in flight,
// with a bounded wait that answers with err instead of stalling the requester.
module memory_arbiter
  import memory_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIXED_PRIORITY = 0,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input logic clock,
  input logic reset_n,
  memory_arbiter_if.slave bus
);
  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  arb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] ack_q, ack_d, mask_q;
  logic err_q, err_d;
  logic valid_q, valid_d;
  logic we_q, we_d;
  logic gid_q, gid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [1:0] eligible;
  logic win, any, take, expired;
  // a port acked last cycle sits out one arbitration so it can drop or renew req
  assign eligible = bus.req & ~mask_q;
  assign take = state_q == ARB_IDLE && any;
  assign expired = cnt_q + 1'b1 == CW'(TIMEOUT_CYCLES);
  rr_arbiter_2 #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_rr (
    .clock     (clock),
    .reset_n   (reset_n),
    .eligible_i(eligible),
    .take_i    (take),
    .grant_o   (win),
    .any_o     (any)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ack_d = 2'b00;
    err_d = err_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    we_d = we_q;
    gid_d = gid_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    if (take) begin
      state_d = ARB_BUSY;
      cnt_d = '0;
      valid_d = 1'b1;
      gid_d = win;
      we_d = bus.we[win];
      addr_d = win ? bus.addr1 : bus.addr0;
      wdata_d = win ? bus.wdata1 : bus.wdata0;
      wstrb_d = bus.we[win] ? (win ? bus.wstrb1 : bus.wstrb0) : '0;
    end else if (state_q == ARB_BUSY) begin
      cnt_d = expired ? cnt_q : cnt_q + 1'b1;
      if (bus.mem_ready || expired) begin
        state_d = ARB_RESP;
        valid_d = 1'b0;
        ack_d = port_onehot(gid_q);
        err_d = !bus.mem_ready;
        rdata_d = bus.mem_ready && !we_q ? bus.mem_rdata : '0;
      end
    end else if (state_q == ARB_RESP) begin
      state_d = ARB_IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      cnt_q <= '0;
      ack_q <= '0;
      mask_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      we_q <= 1'b0;
      gid_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      mask_q <= ack_q;
      err_q <= err_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      we_q <= we_d;
      gid_q <= gid_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end
  assign bus.ack = ack_q;
  assign bus.err = err_q;
  assign bus.rdata = rdata_q;
  assign bus.mem_valid = valid_q;
  assign bus.mem_we = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.grant_id = gid_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and randomized transactions checked against a transaction-level model
module tb_memory_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  int last_grant = 1;
  memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fbus ();
  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(0), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clk), .reset_n(rst_n), .bus(bus));
  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1), .TIMEOUT_CYCLES(TO)) dut_fx (
    .clock(clk), .reset_n(rst_n), .bus(fbus));
  assign fbus.req = bus.req;
  assign fbus.we = bus.we;
  assign fbus.addr0 = bus.addr0;
  assign fbus.addr1 = bus.addr1;
  assign fbus.wdata0 = bus.wdata0;
  assign fbus.wdata1 = bus.wdata1;
  assign fbus.wstrb0 = bus.wstrb0;
  assign fbus.wstrb1 = bus.wstrb1;
  assign fbus.mem_ready = bus.mem_ready;
  assign fbus.mem_rdata = bus.mem_rdata;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive_idle();
    bus.req = 2'b00;
    bus.we = 2'b00;
    bus.addr0 = '0;
    bus.addr1 = '0;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
    bus.wstrb0 = '0;
    bus.wstrb1 = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_grant = 1;
  endtask

  // Issue a request pattern and follow every resulting access through BUSY, ack and idle.
  task automatic run_txn(input logic [1:0] pat, input logic [1:0] wes,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                         input int w0, input int w1,
                         input logic [DW-1:0] r0, input logic [DW-1:0] r1);
    int order[$];
    int p, w, lim;
    bit to;
    logic [DW-1:0] er;
    logic [AW+DW+SW+1:0] em, om;
    if (pat == 2'b11) begin
      order.push_back(last_grant == 0 ? 1 : 0);
      order.push_back(last_grant == 0 ? 0 : 1);
    end else begin
      order.push_back(pat[1] ? 1 : 0);
    end
    last_grant = order[order.size() - 1];
    bus.req = pat;
    bus.we = wes;
    bus.addr0 = a0;
    bus.addr1 = a1;
    bus.wdata0 = d0;
    bus.wdata1 = d1;
    bus.wstrb0 = s0;
    bus.wstrb1 = s1;
    bus.mem_ready = 1'b0;
    er = '0;
    foreach (order[k]) begin
      p = order[k];
      w = p ? w1 : w0;
      to = w + 1 > TO;
      lim = to ? TO : w + 1;
      em = {wes[p], p ? a1 : a0, p ? d1 : d0, wes[p] ? (p ? s1 : s0) : SW'(0), p[0]};
      er = (to || wes[p]) ? '0 : (p ? r1 : r0);
      for (int c = 1; c <= lim; c++) begin
        @(negedge clk);
        om = {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.grant_id};
        compared++;
        if (bus.mem_valid !== 1'b1 || bus.ack !== 2'b00 || om !== em) begin
          mismatched++;
          $display("FAIL busy port%0d cycle%0d: valid=%b ack=%b fields=%h, required valid=1 ack=00 fields=%h",
                   p, c, bus.mem_valid, bus.ack, om, em);
        end
        if (c == 1) begin
          if (p == 1) begin
            bus.addr1 = $urandom;
            bus.wdata1 = $urandom;
          end else begin
            bus.addr0 = $urandom;
            bus.wdata0 = $urandom;
          end
          bus.we[p] = ~bus.we[p];
        end
        bus.mem_ready = !to && c == lim;
        bus.mem_rdata = bus.mem_ready ? (p ? r1 : r0) : DW'($urandom);
      end
      @(negedge clk);
      bus.mem_ready = 1'b0;
      compared++;
      if (bus.ack !== (p ? 2'b10 : 2'b01) || bus.err !== to || bus.rdata !== er || bus.mem_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL ack port%0d: ack=%b err=%b rdata=%h valid=%b, required ack=%b err=%b rdata=%h valid=0",
                 p, bus.ack, bus.err, bus.rdata, bus.mem_valid, p ? 2'b10 : 2'b01, to, er);
      end
      @(negedge clk);
      compared++;
      if (bus.ack !== 2'b00 || bus.mem_valid !== 1'b0 || bus.err !== to || bus.rdata !== er) begin
        mismatched++;
        $display("FAIL post_ack port%0d: ack=%b valid=%b err=%b rdata=%h, required ack=00 valid=0 err=%b rdata=%h",
                 p, bus.ack, bus.mem_valid, bus.err, bus.rdata, to, er);
      end
      bus.req[p] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      bus.mem_ready = 1'($urandom);
      @(negedge clk);
      compared++;
      if (bus.ack !== 2'b00 || bus.mem_valid !== 1'b0 || bus.rdata !== er) begin
        mismatched++;
        $display("FAIL idle: ack=%b valid=%b rdata=%h, required ack=00 valid=0 rdata=%h",
                 bus.ack, bus.mem_valid, bus.rdata, er);
      end
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    bus.req = 2'b11;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if ({bus.ack, bus.err, bus.rdata, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata,
         bus.mem_wstrb, bus.grant_id} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: ack=%b err=%b rdata=%h valid=%b we=%b addr=%h wdata=%h wstrb=%h gid=%b, required all 0",
               bus.ack, bus.err, bus.rdata, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata,
               bus.mem_wstrb, bus.grant_id);
    end
    compared++;
    if ({fbus.ack, fbus.mem_valid, fbus.grant_id} !== '0) begin
      mismatched++;
      $display("FAIL reset_fixed: ack=%b valid=%b gid=%b, required 0", fbus.ack, fbus.mem_valid, fbus.grant_id);
    end
    rst_n = 1'b1;
    drive_idle();
    last_grant = 1;
    @(negedge clk);
    compared++;
    if (bus.mem_valid !== 1'b0 || bus.ack !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_release: valid=%b ack=%b, required 0", bus.mem_valid, bus.ack);
    end
  endtask

  task automatic test_core_read();
    run_txn(2'b01, 2'b00, 32'h0000_0010, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0, 0, 0, 32'h0050_0093, 32'h0);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 2; i++)
      run_txn(2'b11, 2'($urandom), $urandom, $urandom, $urandom, $urandom, SW'($urandom), SW'($urandom),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom, $urandom);
  endtask

  task automatic test_priority_reset();
    int exp_rr;
    do_reset();
    run_txn(2'b01, 2'b00, $urandom, $urandom, $urandom, $urandom, 4'h0, 4'h0, 0, 0, $urandom, $urandom);
    exp_rr = last_grant == 0 ? 1 : 0;
    bus.req = 2'b11;
    bus.addr0 = $urandom;
    bus.addr1 = $urandom;
    @(negedge clk);
    compared++;
    if (bus.mem_valid !== 1'b1 || bus.grant_id !== exp_rr[0]) begin
      mismatched++;
      $display("FAIL rr_tie: valid=%b gid=%b, required valid=1 gid=%0d", bus.mem_valid, bus.grant_id, exp_rr);
    end
    compared++;
    if (fbus.mem_valid !== 1'b1 || fbus.grant_id !== 1'b0) begin
      mismatched++;
      $display("FAIL fixed_tie: valid=%b gid=%b, required valid=1 gid=0", fbus.mem_valid, fbus.grant_id);
    end
    rst_n = 1'b0;
    @(negedge clk);
    compared++;
    if ({bus.mem_valid, bus.ack, bus.grant_id, bus.err, fbus.mem_valid} !== '0) begin
      mismatched++;
      $display("FAIL reset_busy: valid=%b ack=%b gid=%b err=%b fixed_valid=%b, required all 0",
               bus.mem_valid, bus.ack, bus.grant_id, bus.err, fbus.mem_valid);
    end
    rst_n = 1'b1;
    last_grant = 1;
    run_txn(2'b11, 2'b01, $urandom, $urandom, $urandom, $urandom, 4'hA, 4'h5, 1, 0, $urandom, $urandom);
  endtask

  task automatic test_dma_write();
    run_txn(2'b10, 2'b10, $urandom, 32'h0000_0100, $urandom, 32'hDEAD_BEEF, 4'hF, 4'b0011, 0, 3,
            32'h1111_1111, 32'hCAFE_F00D);
  endtask

  task automatic test_timeout();
    run_txn(2'b01, 2'b00, 32'h0000_0200, $urandom, $urandom, $urandom, 4'h0, 4'h0, 20, 0,
            32'h7777_7777, $urandom);
    run_txn(2'b01, 2'b00, 32'h0000_0204, $urandom, $urandom, $urandom, 4'h0, 4'h0, 1, 0,
            32'h0123_4567, $urandom);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    drive_idle();
    bus.req = 2'b01;
    bus.addr0 = 32'h0000_0040;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      exp = (t >= 2 && t <= 14 && (t - 2) % 4 == 0) ? 2'b01 : 2'b00;
      compared++;
      if (bus.ack !== exp) begin
        mismatched++;
        $display("FAIL back_to_back t=%0d: ack=%b, required %b", t, bus.ack, exp);
      end
      if (t == 13) bus.req = 2'b00;
    end
    bus.mem_ready = 1'b0;
    last_grant = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++)
      run_txn(2'($urandom_range(1, 3)), 2'($urandom), $urandom, $urandom, $urandom, $urandom,
              SW'($urandom), SW'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
              $urandom, $urandom);
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_round_robin();
    test_priority_reset();
    test_dma_write();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
